icache: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/icache.sv | 86 ++++++++
 tb/tb_icache.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: frame layout, miss FSM states and
// the default index/tag split for a 16-frame cache.
package cpu_types_pkg;

    localparam int IIDX_W = 4;
    localparam int ITAG_W = 30 - IIDX_W;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single-word
// fills from the memory controller on a miss.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS];

    icache_state_t state_q, state_d;
    logic [29:0]   miss_word_q;

    logic [IW-1:0] req_idx, miss_idx;
    logic [TW-1:0] req_tag, miss_tag;
    logic          hit, fill_done;
    logic          unused_offset;

    assign req_idx       = imemaddr[IW+1:2];
    assign req_tag       = imemaddr[31:IW+2];
    assign miss_idx      = miss_word_q[IW-1:0];
    assign miss_tag      = miss_word_q[29:IW];
    assign unused_offset = ^imemaddr[1:0];

    assign hit       = (state_q == IDLE) && imemREN && valid_q[req_idx]
                       && (tag_q[req_idx] == req_tag);
    assign fill_done = (state_q == FILL) && !iwait;

    assign ihit     = hit;
    assign imemload = hit ? data_q[req_idx] : 32'h0;
    assign iREN     = (state_q == FILL);
    assign iaddr    = (state_q == FILL) ? {miss_word_q, 2'b00} : 32'h0;

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (imemREN && !hit) state_d = FILL;
            FILL:    if (!iwait)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_word_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && imemREN && !hit)
                miss_word_q <= imemaddr[31:2];
            if (fill_done)
                valid_q[miss_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data carry no reset; the valid bits alone qualify them,
    // which keeps the array as plain storage.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: scoreboard of expected fetch data, bench-side
// memory controller with programmable wait states.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int errors = 0;
    int checks = 0;
    int hit_cycle;
    int ren_cycles;
    logic [31:0] sb [$];

    icache #(.SETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'h10) return 32'h3C010001;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Entered 1ns after a rising edge; returns 1ns after the edge ending the hit cycle.
    task automatic fetch(input logic [31:0] addr, input int waits, input bit exp_hit, input string tag);
        int  cyc  = 0;
        int  wcnt = 0;
        bit  done = 0;
        logic [31:0] exp;
        imemREN  = 1'b1;
        imemaddr = addr;
        sb.push_back(mem_word(addr));
        ren_cycles = 0;
        while (!done && cyc < 40) begin
            #1;
            if (cyc == 0) check({tag, "_first_hit"}, {31'h0, ihit}, {31'h0, exp_hit});
            if (ihit) begin
                exp = sb.pop_front();
                check({tag, "_data"}, imemload, exp);
                done = 1;
                iwait = 1'b1;
            end else if (iREN) begin
                check({tag, "_iaddr"}, iaddr, {addr[31:2], 2'b00});
                ren_cycles++;
                iwait = (wcnt < waits);
                iload = iwait ? 32'hDEAD_BEEF : mem_word(addr);
                wcnt++;
            end else begin
                iwait = 1'b1;
                iload = 32'h0;
            end
            hit_cycle = cyc;
            next_cycle();
            cyc++;
        end
        iwait = 1'b1;
        if (!done) begin
            check({tag, "_timeout"}, 32'h0, 32'h1);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        iwait    = 1'b1;
        iload    = 32'h0;
        #12;
        check("rst_ihit",     {31'h0, ihit}, 32'h0);
        check("rst_imemload", imemload,      32'h0);
        check("rst_iREN",     {31'h0, iREN}, 32'h0);
        check("rst_iaddr",    iaddr,         32'h0);
        imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        next_cycle();

        // Cold miss with three wait states, then an immediate re-hit.
        fetch(32'h0000_0040, 3, 1'b0, "miss40");
        check("miss40_ren_cycles", ren_cycles, 4);
        check("miss40_hit_cycle",  hit_cycle,  5);
        fetch(32'h0000_0040, 0, 1'b1, "rehit40");
        check("rehit40_hit_cycle", hit_cycle, 0);

        // No request: nothing reported even for a cached address.
        imemREN = 1'b0;
        #1;
        check("noren_ihit",     {31'h0, ihit}, 32'h0);
        check("noren_imemload", imemload,      32'h0);
        next_cycle();

        // Aliasing frames; also the minimum miss penalty.
        fetch(32'h0000_0004, 0, 1'b0, "miss04");
        check("miss04_hit_cycle", hit_cycle, 2);
        fetch(32'h0000_0044, 0, 1'b0, "alias44");
        fetch(32'h0000_0004, 0, 1'b0, "remiss04");
        fetch(32'h0000_0044, 1, 1'b0, "remiss44");

        // Redirect and drop the request mid-fill.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        next_cycle();
        imemaddr = 32'h0000_0200;
        imemREN  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iwait = 1'b1;
            #1;
            check("redir_iREN",  {31'h0, iREN}, 32'h1);
            check("redir_iaddr", iaddr,         32'h0000_0100);
            check("redir_ihit",  {31'h0, ihit}, 32'h0);
            next_cycle();
        end
        iwait = 1'b0;
        iload = mem_word(32'h0000_0100);
        next_cycle();
        iwait = 1'b1;
        #1;
        check("redir_done_iREN", {31'h0, iREN}, 32'h0);
        next_cycle();
        fetch(32'h0000_0200, 0, 1'b0, "redir_miss200");
        fetch(32'h0000_0100, 0, 1'b0, "redir_evicted100");
        fetch(32'h0000_0044, 0, 1'b1, "hit44");

        // Reset while a fill is outstanding.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0300;
        next_cycle();
        iwait = 1'b1;
        #1;
        check("rstfill_iREN_before", {31'h0, iREN}, 32'h1);
        #1;
        nRST = 1'b0;
        #1;
        check("rstfill_iREN_async",  {31'h0, iREN}, 32'h0);
        check("rstfill_iaddr_async", iaddr,         32'h0);
        imemREN = 1'b0;
        next_cycle();
        nRST = 1'b1;
        #1;
        check("rstfill_iREN_after", {31'h0, iREN}, 32'h0);
        next_cycle();
        fetch(32'h0000_0044, 0, 1'b0, "rstfill_miss44");

        // Sixteen sequential words, then re-read them all.
        for (int i = 0; i < 16; i++)
            fetch(32'h0000_1000 + 32'(i * 4), i % 3, 1'b0, "seq_fill");
        for (int i = 0; i < 16; i++)
            fetch(32'h0000_1000 + 32'(i * 4), 0, 1'b1, "seq_reread");
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
